alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 102 ++++++++++
 tb/tb_alu_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU, feeding a one-entry
// result register with a valid/ready handshake on both sides.
module alu_arbiter #(
    parameter int unsigned WIDTH    = 16,
    parameter logic [1:0]  OP_ADD   = 2'd0,
    parameter logic [1:0]  OP_AND   = 2'd1,
    parameter logic [1:0]  OP_XOR   = 2'd2,
    parameter logic [1:0]  OP_PASSA = 2'd3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0_VALID,
    input  logic [1:0]       REQ0_OP,
    input  logic [WIDTH-1:0] REQ0_A,
    input  logic [WIDTH-1:0] REQ0_B,
    output logic             REQ0_READY,
    input  logic             REQ1_VALID,
    input  logic [1:0]       REQ1_OP,
    input  logic [WIDTH-1:0] REQ1_A,
    input  logic [WIDTH-1:0] REQ1_B,
    output logic             REQ1_READY,
    output logic             RES_VALID,
    output logic             RES_ID,
    output logic [WIDTH-1:0] RES_DATA,
    output logic [2:0]       RES_NZP,
    input  logic             RES_READY
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e             state_q;
    logic               last_q;
    logic               id_q;
    logic [WIDTH-1:0]   data_q;
    logic [2:0]         nzp_q;

    logic               free;
    logic               acc0;
    logic               acc1;
    logic               accept;
    logic [1:0]         op_sel;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [WIDTH-1:0]   alu_res;
    logic [2:0]         alu_nzp;

    // Arbitration: READY ignores the requester's own VALID; LAST breaks ties.
    always_comb begin
        free       = (state_q == StEmpty) || RES_READY;
        REQ0_READY = !RESET && free && (!REQ1_VALID || last_q);
        REQ1_READY = !RESET && free && (!REQ0_VALID || !last_q);
        acc0       = REQ0_VALID && REQ0_READY;
        acc1       = REQ1_VALID && REQ1_READY;
        accept     = acc0 || acc1;
    end

    // Single shared ALU; operands steered by the granted requester.
    always_comb begin
        op_sel = acc1 ? REQ1_OP : REQ0_OP;
        a_sel  = acc1 ? REQ1_A  : REQ0_A;
        b_sel  = acc1 ? REQ1_B  : REQ0_B;
        case (op_sel)
            OP_ADD:  alu_res = a_sel + b_sel;
            OP_AND:  alu_res = a_sel & b_sel;
            OP_XOR:  alu_res = a_sel ^ b_sel;
            OP_PASSA: alu_res = a_sel;
            default: alu_res = a_sel;
        endcase
        if (alu_res[WIDTH-1]) begin
            alu_nzp = 3'b100;
        end else if (alu_res == '0) begin
            alu_nzp = 3'b010;
        end else begin
            alu_nzp = 3'b001;
        end
    end

    // Result register FSM: load on acceptance, drain when consumed with no new work.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StEmpty;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            data_q  <= '0;
            nzp_q   <= 3'b000;
        end else if (accept) begin
            state_q <= StFull;
            last_q  <= acc1;
            id_q    <= acc1;
            data_q  <= alu_res;
            nzp_q   <= alu_nzp;
        end else if (free) begin
            state_q <= StEmpty;
        end
    end

    assign RES_VALID = (state_q == StFull);
    assign RES_ID    = id_q;
    assign RES_DATA  = data_q;
    assign RES_NZP   = nzp_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

    localparam int unsigned W = 16;
    localparam logic [1:0] ADD = 2'd0;
    localparam logic [1:0] AND = 2'd1;
    localparam logic [1:0] XOR = 2'd2;
    localparam logic [1:0] PSA = 2'd3;

    logic         clk = 1'b0;
    logic         rst;
    logic         v0, v1, r0, r1;
    logic [1:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         res_valid, res_id, res_ready;
    logic [W-1:0] res_data;
    logic [2:0]   res_nzp;

    int tests = 0;
    int fails = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .CLK(clk), .RESET(rst),
        .REQ0_VALID(v0), .REQ0_OP(op0), .REQ0_A(a0), .REQ0_B(b0), .REQ0_READY(r0),
        .REQ1_VALID(v1), .REQ1_OP(op1), .REQ1_A(a1), .REQ1_B(b1), .REQ1_READY(r1),
        .RES_VALID(res_valid), .RES_ID(res_id), .RES_DATA(res_data),
        .RES_NZP(res_nzp), .RES_READY(res_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        v0 = v; op0 = op; a0 = a; b0 = b;
    endtask

    task automatic set1(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        v1 = v; op1 = op; a1 = a; b1 = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; res_ready = 1'b1;
        set0(1'b1, ADD, 16'h0001, 16'h0001);
        set1(1'b1, ADD, 16'h0001, 16'h0001);
        #1;
        tests++;
        if ({r0, r1} !== 2'b00) begin
            $display("FAIL reset_ready got=%b exp=00", {r0, r1}); fails++;
        end
        tick(); tick();
        tests++;
        if ({res_valid, res_id, res_data, res_nzp} !== {1'b0, 1'b0, 16'h0000, 3'b000}) begin
            $display("FAIL reset_state got v=%b id=%b d=%h nzp=%b exp 0/0/0000/000",
                     res_valid, res_id, res_data, res_nzp);
            fails++;
        end
        set0(1'b0, ADD, '0, '0); set1(1'b0, ADD, '0, '0);
        rst = 1'b0;
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        set0(1'b1, ADD, 16'h0001, 16'h0001);
        #1;
        tests++;
        if (r0 !== 1'b1) begin
            $display("FAIL single_ready got=%b exp=1", r0); fails++;
        end
        tick();
        set0(1'b0, ADD, '0, '0);
        tests++;
        if ({res_valid, res_id, res_data, res_nzp} !== {1'b1, 1'b0, 16'h0002, 3'b001}) begin
            $display("FAIL single_result got v=%b id=%b d=%h nzp=%b exp 1/0/0002/001",
                     res_valid, res_id, res_data, res_nzp);
            fails++;
        end
        tick();
        tests++;
        if (res_valid !== 1'b0) begin
            $display("FAIL single_drain got=%b exp=0", res_valid); fails++;
        end
    endtask

    task automatic test_ops();
        logic [1:0]   ops [4];
        logic [W-1:0] as  [4];
        logic [W-1:0] bs  [4];
        logic [W-1:0] exd [4];
        logic [2:0]   exn [4];
        ops = '{AND, XOR, PSA, ADD};
        as  = '{16'h0002, 16'h1000, 16'h1000, 16'hFFFF};
        bs  = '{16'h0001, 16'h0001, 16'h0000, 16'h0001};
        exd = '{16'h0000, 16'h1001, 16'h1000, 16'h0000};
        exn = '{3'b010, 3'b001, 3'b001, 3'b010};
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set1(1'b1, ops[i], as[i], bs[i]);
            tick();
            tests++;
            if ({res_valid, res_id, res_data, res_nzp} !== {1'b1, 1'b1, exd[i], exn[i]}) begin
                $display("FAIL op_%0d got v=%b id=%b d=%h nzp=%b exp 1/1/%h/%b", i,
                         res_valid, res_id, res_data, res_nzp, exd[i], exn[i]);
                fails++;
            end
        end
        set1(1'b0, ADD, '0, '0);
        tick();
    endtask

    task automatic test_fairness();
        rst = 1'b1; tick(); rst = 1'b0;
        res_ready = 1'b1;
        set0(1'b1, ADD, 16'h0010, 16'h0000);
        set1(1'b1, ADD, 16'h0020, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++;
            if (r0 && r1) begin
                $display("FAIL fair_both_ready cycle=%0d got=11 exp=one-hot", i); fails++;
            end
            tick();
            tests++;
            if ({res_valid, res_id} !== {1'b1, 1'(i % 2)}) begin
                $display("FAIL fair_id cycle=%0d got v=%b id=%b exp 1/%0d", i,
                         res_valid, res_id, i % 2);
                fails++;
            end
        end
        set0(1'b0, ADD, '0, '0); set1(1'b0, ADD, '0, '0);
        tick();
    endtask

    task automatic test_backpressure();
        res_ready = 1'b1;
        set0(1'b1, PSA, 16'h8000, 16'h0000);
        tick();
        res_ready = 1'b0;
        set0(1'b1, ADD, 16'h0001, 16'h0002);
        set1(1'b1, ADD, 16'h0004, 16'h0004);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if ({r0, r1} !== 2'b00) begin
                $display("FAIL bp_ready cycle=%0d got=%b exp=00", i, {r0, r1}); fails++;
            end
            tick();
            tests++;
            if ({res_valid, res_data, res_nzp} !== {1'b1, 16'h8000, 3'b100}) begin
                $display("FAIL bp_hold cycle=%0d got v=%b d=%h nzp=%b exp 1/8000/100", i,
                         res_valid, res_data, res_nzp);
                fails++;
            end
        end
        set1(1'b0, ADD, '0, '0);
        res_ready = 1'b1;
        #1;
        tests++;
        if (r0 !== 1'b1) begin
            $display("FAIL bp_release_ready got=%b exp=1", r0); fails++;
        end
        tick();
        set0(1'b0, ADD, '0, '0);
        tests++;
        if ({res_valid, res_id, res_data, res_nzp} !== {1'b1, 1'b0, 16'h0003, 3'b001}) begin
            $display("FAIL bp_next got v=%b id=%b d=%h nzp=%b exp 1/0/0003/001",
                     res_valid, res_id, res_data, res_nzp);
            fails++;
        end
        tick();
    endtask

    task automatic test_drain();
        // last granted REQ1, drain, then tie must go to REQ0
        res_ready = 1'b1;
        set1(1'b1, PSA, 16'h0005, 16'h0000);
        tick();
        set1(1'b0, ADD, '0, '0);
        tick();
        tests++;
        if (res_valid !== 1'b0) begin
            $display("FAIL drain_valid got=%b exp=0", res_valid); fails++;
        end
        tick();
        set0(1'b1, ADD, 16'h0001, 16'h0000);
        set1(1'b1, ADD, 16'h0002, 16'h0000);
        tick();
        tests++;
        if ({res_valid, res_id} !== 2'b10) begin
            $display("FAIL drain_tie_after1 got v=%b id=%b exp 1/0", res_valid, res_id);
            fails++;
        end
        // last granted REQ0 now; drain then tie must go to REQ1
        set0(1'b0, ADD, '0, '0); set1(1'b0, ADD, '0, '0);
        tick(); tick();
        set0(1'b1, ADD, 16'h0001, 16'h0000);
        set1(1'b1, ADD, 16'h0002, 16'h0000);
        tick();
        tests++;
        if ({res_valid, res_id, res_data} !== {1'b1, 1'b1, 16'h0002}) begin
            $display("FAIL drain_tie_after0 got v=%b id=%b d=%h exp 1/1/0002",
                     res_valid, res_id, res_data);
            fails++;
        end
        set0(1'b0, ADD, '0, '0); set1(1'b0, ADD, '0, '0);
        tick();
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        set0(1'b1, PSA, 16'h0077, 16'h0000);
        tick();
        res_ready = 1'b0;
        set1(1'b1, PSA, 16'h0066, 16'h0000);
        rst = 1'b1;
        #1;
        tests++;
        if ({r0, r1} !== 2'b00) begin
            $display("FAIL rstmid_ready got=%b exp=00", {r0, r1}); fails++;
        end
        tick();
        rst = 1'b0;
        tests++;
        if ({res_valid, res_data} !== {1'b0, 16'h0000}) begin
            $display("FAIL rstmid_state got v=%b d=%h exp 0/0000", res_valid, res_data);
            fails++;
        end
        res_ready = 1'b1;
        #1;
        tests++;
        if ({r0, r1} !== 2'b10) begin
            $display("FAIL rstmid_tie_ready got=%b exp=10", {r0, r1}); fails++;
        end
        tick();
        tests++;
        if ({res_valid, res_id, res_data} !== {1'b1, 1'b0, 16'h0077}) begin
            $display("FAIL rstmid_tie got v=%b id=%b d=%h exp 1/0/0077",
                     res_valid, res_id, res_data);
            fails++;
        end
        set0(1'b0, ADD, '0, '0); set1(1'b0, ADD, '0, '0);
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_ops();
        test_fairness();
        test_backpressure();
        test_drain();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
